fetch_stage: RTL and testbench

//  Instruction fetch stage that feeds the control unit and decode path. Holds the PC and

---
 rtl/fetch_stage.sv | 154 +++++++++++++++
 tb/tb_fetch_stage.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, issues one imem request at a time,
// and hands {instr, instr_pc} to decode through a one-entry skid buffer.
module fetch_stage #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_ready,
  input  logic                  imem_rvalid,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  input  logic                  PCSrc,
  input  logic [ADDR_WIDTH-1:0] redirect_target,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  instr_valid,
  input  logic                  dec_ready
);

  typedef enum logic [1:0] {
    S_RESET,
    S_REQ,
    S_WAIT,
    S_HOLD
  } state_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0] pc;
  } slot_t;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic                  kill_q, kill_d;
  logic                  skid_vld_q, skid_vld_d;
  slot_t                 skid_q, skid_d;
  logic                  out_vld_q, out_vld_d;
  slot_t                 out_q, out_d;

  logic [ADDR_WIDTH-1:0] redir_pc;
  logic                  slot_free;
  logic                  consume;
  slot_t                 resp;
  logic                  unused_tgt_lsb;

  assign redir_pc       = {redirect_target[ADDR_WIDTH-1:2], 2'b00};
  assign unused_tgt_lsb = ^redirect_target[1:0];
  assign consume        = out_vld_q & dec_ready;
  assign slot_free      = !out_vld_q || dec_ready;
  assign resp           = '{instr: imem_rdata, pc: fetch_pc_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_RESET;
      pc_q       <= RESET_PC;
      fetch_pc_q <= '0;
      kill_q     <= 1'b0;
      skid_vld_q <= 1'b0;
      skid_q     <= '0;
      out_vld_q  <= 1'b0;
      out_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fetch_pc_q <= fetch_pc_d;
      kill_q     <= kill_d;
      skid_vld_q <= skid_vld_d;
      skid_q     <= skid_d;
      out_vld_q  <= out_vld_d;
      out_q      <= out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RESET: state_d = S_REQ;
      S_REQ: begin
        if (imem_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (PCSrc) begin
          state_d = imem_rvalid ? S_REQ : S_WAIT;
        end else if (imem_rvalid) begin
          state_d = (kill_q || slot_free) ? S_REQ : S_HOLD;
        end
      end
      S_HOLD: begin
        if (PCSrc || dec_ready) state_d = S_REQ;
      end
      default: state_d = S_RESET;
    endcase
  end

  always_comb begin
    pc_d       = pc_q;
    fetch_pc_d = fetch_pc_q;
    kill_d     = kill_q;
    skid_vld_d = skid_vld_q;
    skid_d     = skid_q;
    out_vld_d  = consume ? 1'b0 : out_vld_q;
    out_d      = out_q;
    unique case (state_q)
      S_REQ: begin
        if (imem_ready) begin
          fetch_pc_d = pc_q;
          pc_d       = pc_q + ADDR_WIDTH'(4);
        end
      end
      S_WAIT: begin
        if (imem_rvalid && !PCSrc) begin
          if (kill_q) begin
            kill_d = 1'b0;
          end else if (slot_free) begin
            out_d     = resp;
            out_vld_d = 1'b1;
          end else begin
            skid_d     = resp;
            skid_vld_d = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (dec_ready && skid_vld_q) begin
          out_d      = skid_q;
          out_vld_d  = 1'b1;
          skid_vld_d = 1'b0;
        end
      end
      default: ;
    endcase
    // Redirect wins: anything already in flight becomes stale.
    if (PCSrc) begin
      pc_d       = redir_pc;
      out_vld_d  = 1'b0;
      skid_vld_d = 1'b0;
      if (state_q == S_REQ && imem_ready) kill_d = 1'b1;
      if (state_q == S_WAIT) kill_d = !imem_rvalid;
    end
  end

  always_comb begin
    imem_req    = (state_q == S_REQ);
    imem_addr   = imem_req ? pc_q : '0;
    instr       = out_q.instr;
    instr_pc    = out_q.pc;
    instr_valid = out_vld_q;
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: handshake, stalls, skid,
// redirects, wrap and asynchronous reset.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        PCSrc = 1'b0;
  logic [31:0] redirect_target = '0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        dec_ready = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  fetch_stage #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .RESET_PC  (32'h0)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .PCSrc          (PCSrc),
    .redirect_target(redirect_target),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_valid    (instr_valid),
    .dec_ready      (dec_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] dat(input logic [31:0] a);
    return {a[15:0], 16'h0013} ^ 32'h5A00_0000;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_req(input string tag, input logic r,
                         input logic [31:0] a);
    check({tag, "_req"}, 64'(imem_req), 64'(r));
    if (r) check({tag, "_addr"}, 64'(imem_addr), 64'(a));
  endtask

  task automatic chk_out(input string tag, input logic v,
                         input logic [31:0] pc);
    check({tag, "_vld"}, 64'(instr_valid), 64'(v));
    if (v) begin
      check({tag, "_pc"}, 64'(instr_pc), 64'(pc));
      check({tag, "_ins"}, 64'(instr), 64'(dat(pc)));
    end
  endtask

  initial begin
    #12;
    check("rst_req", 64'(imem_req), 64'd0);
    check("rst_addr", 64'(imem_addr), 64'd0);
    check("rst_vld", 64'(instr_valid), 64'd0);
    check("rst_ins", 64'(instr), 64'd0);
    check("rst_ipc", 64'(instr_pc), 64'd0);
    rst_n = 1'b1;
    step();
    chk_req("rel", 1'b1, 32'h0);

    // basic flow
    imem_ready = 1'b1; dec_ready = 1'b1;
    step();
    chk_req("t1a", 1'b0, 32'h0);
    imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = dat(32'h0);
    step();
    chk_out("t1b", 1'b1, 32'h0);
    chk_req("t1b", 1'b1, 32'h4);
    imem_rvalid = 1'b0; imem_ready = 1'b1;
    step();
    chk_out("t1c", 1'b0, 32'h0);
    chk_req("t1c", 1'b0, 32'h0);
    imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = dat(32'h4);
    step();
    chk_out("t1d", 1'b1, 32'h4);
    chk_req("t1d", 1'b1, 32'h8);

    // memory stall in REQ
    imem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_req("t2stall", 1'b1, 32'h8);
    end
    imem_ready = 1'b1;
    step();
    chk_req("t2acc", 1'b0, 32'h0);
    imem_ready = 1'b0;
    step();
    chk_req("t2one", 1'b0, 32'h0);
    imem_rvalid = 1'b1; imem_rdata = dat(32'h8);
    step();
    chk_out("t2d", 1'b1, 32'h8);
    chk_req("t2d", 1'b1, 32'hC);

    // decode stall, skid buffer
    imem_rvalid = 1'b0; dec_ready = 1'b0; imem_ready = 1'b1;
    step();
    chk_out("t3a", 1'b1, 32'h8);
    chk_req("t3a", 1'b0, 32'h0);
    imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = dat(32'hC);
    step();
    chk_out("t3b", 1'b1, 32'h8);
    chk_req("t3b", 1'b0, 32'h0);
    imem_rdata = 32'hDEAD_BEEF;
    step();
    chk_out("t3c", 1'b1, 32'h8);
    chk_req("t3c", 1'b0, 32'h0);
    imem_rvalid = 1'b0;
    step();
    chk_out("t3d", 1'b1, 32'h8);
    chk_req("t3d", 1'b0, 32'h0);
    dec_ready = 1'b1;
    step();
    chk_out("t3e", 1'b1, 32'hC);
    chk_req("t3e", 1'b1, 32'h10);
    step();
    chk_out("t3f", 1'b0, 32'h0);
    chk_req("t3f", 1'b1, 32'h10);

    // redirect while waiting
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0; PCSrc = 1'b1; redirect_target = 32'h103;
    step();
    chk_req("t4a", 1'b0, 32'h0);
    PCSrc = 1'b0; imem_rvalid = 1'b1; imem_rdata = dat(32'h10);
    step();
    chk_out("t4b", 1'b0, 32'h0);
    chk_req("t4b", 1'b1, 32'h100);
    imem_rvalid = 1'b0; imem_ready = 1'b1;
    step();
    imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = dat(32'h100);
    step();
    chk_out("t4c", 1'b1, 32'h100);
    chk_req("t4c", 1'b1, 32'h104);

    // redirect in the accepting cycle
    imem_rvalid = 1'b0; imem_ready = 1'b1;
    PCSrc = 1'b1; redirect_target = 32'h200;
    step();
    chk_out("t5a", 1'b0, 32'h0);
    chk_req("t5a", 1'b0, 32'h0);
    imem_ready = 1'b0; PCSrc = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = dat(32'h104);
    step();
    chk_out("t5b", 1'b0, 32'h0);
    chk_req("t5b", 1'b1, 32'h200);
    imem_rvalid = 1'b0; imem_ready = 1'b1;
    step();
    imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = dat(32'h200);
    step();
    chk_out("t5c", 1'b1, 32'h200);
    chk_req("t5c", 1'b1, 32'h204);

    // redirect in REQ without accept
    imem_rvalid = 1'b0; PCSrc = 1'b1; redirect_target = 32'h3FE;
    step();
    chk_out("t5d", 1'b0, 32'h0);
    chk_req("t5d", 1'b1, 32'h3FC);

    // PC wrap
    redirect_target = 32'hFFFF_FFFF;
    step();
    chk_req("t7a", 1'b1, 32'hFFFF_FFFC);
    PCSrc = 1'b0; imem_ready = 1'b1;
    step();
    imem_ready = 1'b0; imem_rvalid = 1'b1;
    imem_rdata = dat(32'hFFFF_FFFC);
    step();
    chk_out("t7b", 1'b1, 32'hFFFF_FFFC);
    chk_req("t7b", 1'b1, 32'h0);

    // async reset in WAIT, stale response afterwards
    imem_rvalid = 1'b0; dec_ready = 1'b0; imem_ready = 1'b1;
    step();
    chk_out("t6a", 1'b1, 32'hFFFF_FFFC);
    imem_ready = 1'b0; rst_n = 1'b0;
    #1;
    check("t6_vld", 64'(instr_valid), 64'd0);
    check("t6_ins", 64'(instr), 64'd0);
    check("t6_ipc", 64'(instr_pc), 64'd0);
    check("t6_req", 64'(imem_req), 64'd0);
    check("t6_addr", 64'(imem_addr), 64'd0);
    step();
    imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0000;
    step();
    chk_req("t6b", 1'b0, 32'h0);
    rst_n = 1'b1; dec_ready = 1'b1;
    step();
    chk_out("t6c", 1'b0, 32'h0);
    chk_req("t6c", 1'b1, 32'h0);
    imem_rvalid = 1'b0; imem_ready = 1'b1;
    step();
    imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = dat(32'h0);
    step();
    chk_out("t6d", 1'b1, 32'h0);
    chk_req("t6d", 1'b1, 32'h4);
    imem_rvalid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
